// File: rtl/pal_loader_if.sv
// Byte-stream download handshake between the palette downloader (master) and pal_loader (slave).
interface pal_loader_if;
  logic       dl_active;
  logic       dl_wr;
  logic [7:0] dl_data;
  logic       dl_wait;

  modport master (output dl_active, output dl_wr, output dl_data, input dl_wait);
  modport slave  (input dl_active, input dl_wr, input dl_data, output dl_wait);
endinterface

// File: rtl/pal_loader.sv
// Packs downloaded RGB888 triplets into BGR555 words and schedules palette RAM writes.
// Optional vblank write gating is compiled in with PAL_LOADER_VBLANK_GATE_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no download since reset; waiting for dl_active rise
// ST_COLLECT | accepting R,G,B bytes into staging registers
// ST_PENDING | packed word held; dl_wait high until its write completes
// ST_DONE    | download finished; done=1 until the next dl_active rise
module pal_loader #(
  parameter int MAX_ENTRIES = 64
) (
  input  logic              clk,
  input  logic              reset,
  pal_loader_if.slave       dl,
  input  logic              vblank,
  output logic              load_color,
  output logic [5:0]        load_color_index,
  output logic [14:0]       load_color_data,
  output logic              busy,
  output logic              done,
  output logic [6:0]        entries_loaded
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [6:0] MAX_CNT = 7'(MAX_ENTRIES);

  logic [1:0]  state_q, state_d;
  logic        act_q, act_prev_q;
  logic [1:0]  phase_q, phase_d;
  logic [4:0]  r_q, r_d;
  logic [4:0]  g_q, g_d;
  logic [5:0]  pend_idx_q, pend_idx_d;
  logic [14:0] pend_data_q, pend_data_d;
  logic        wr_q, wr_d;
  logic [5:0]  idx_q, idx_d;
  logic [14:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        gate_ok;
  logic        start;

`ifdef PAL_LOADER_VBLANK_GATE_EN
  logic vblank_q;

  // Registered vblank: a write only launches after an edge that saw vblank high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vblank_q <= 1'b0;
    else       vblank_q <= vblank;
  end

  assign gate_ok = vblank_q;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign gate_ok       = 1'b1;
`endif

  assign start = act_q & ~act_prev_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    r_d         = r_q;
    g_d         = g_q;
    pend_idx_d  = pend_idx_q;
    pend_data_d = pend_data_q;
    wr_d        = wr_q;
    idx_d       = idx_q;
    data_d      = data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_COLLECT;
          phase_d = 2'd0;
          cnt_d   = 7'd0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_COLLECT: begin
        if (!act_q) begin
          // Partial R / R,G staging is simply abandoned.
          state_d = ST_DONE;
          phase_d = 2'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (dl.dl_wr) begin
          case (phase_q)
            2'd0: begin
              r_d     = dl.dl_data[7:3];
              phase_d = 2'd1;
            end
            2'd1: begin
              g_d     = dl.dl_data[7:3];
              phase_d = 2'd2;
            end
            default: begin
              phase_d = 2'd0;
              if (cnt_q < MAX_CNT) begin
                pend_data_d = {dl.dl_data[7:3], g_q, r_q};
                pend_idx_d  = cnt_q[5:0];
                state_d     = ST_PENDING;
              end
            end
          endcase
        end
      end

      ST_PENDING: begin
        if (wr_q) begin
          wr_d  = 1'b0;
          cnt_d = cnt_q + 7'd1;
          if (act_q) begin
            state_d = ST_COLLECT;
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else if (gate_ok) begin
          wr_d   = 1'b1;
          idx_d  = pend_idx_q;
          data_d = pend_data_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      act_q       <= 1'b0;
      act_prev_q  <= 1'b0;
      phase_q     <= 2'd0;
      r_q         <= 5'd0;
      g_q         <= 5'd0;
      pend_idx_q  <= 6'd0;
      pend_data_q <= 15'd0;
      wr_q        <= 1'b0;
      idx_q       <= 6'd0;
      data_q      <= 15'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= 7'd0;
    end else begin
      state_q     <= state_d;
      act_q       <= dl.dl_active;
      act_prev_q  <= act_q;
      phase_q     <= phase_d;
      r_q         <= r_d;
      g_q         <= g_d;
      pend_idx_q  <= pend_idx_d;
      pend_data_q <= pend_data_d;
      wr_q        <= wr_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dl.dl_wait        = (state_q == ST_PENDING);
  assign load_color        = wr_q;
  assign load_color_index  = idx_q;
  assign load_color_data   = data_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign entries_loaded    = cnt_q;

endmodule

// File: tb/tb_pal_loader.sv
// Directed self-checking bench for pal_loader: full, oversize, partial, protocol violation, reset abort.
module tb_pal_loader;

  logic        clk;
  logic        reset;
  logic        vblank;
  logic        load_color;
  logic [5:0]  load_color_index;
  logic [14:0] load_color_data;
  logic        busy;
  logic        done;
  logic [6:0]  entries_loaded;

  int n_checks = 0;
  int n_pass   = 0;

  int          wr_total = 0;
  logic [5:0]  idx_log  [0:511];
  logic [14:0] data_log [0:511];

  pal_loader_if dl_if();

  pal_loader #(.MAX_ENTRIES(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .dl               (dl_if),
    .vblank           (vblank),
    .load_color       (load_color),
    .load_color_index (load_color_index),
    .load_color_data  (load_color_data),
    .busy             (busy),
    .done             (done),
    .entries_loaded   (entries_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_color) begin
      if (wr_total < 512) begin
        idx_log[wr_total]  = load_color_index;
        data_log[wr_total] = load_color_data;
      end
      wr_total = wr_total + 1;
    end
  end

  function automatic logic [7:0] pat(int k);
    case (k)
      0:       return 8'hFF;
      1:       return 8'h80;
      2:       return 8'h08;
      default: return 8'((k * 29 + 7) & 255);
    endcase
  endfunction

  function automatic logic [14:0] pack(logic [7:0] r, logic [7:0] g, logic [7:0] b);
    return {b[7:3], g[7:3], r[7:3]};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 2000 && dl_if.dl_wait; i++) @(negedge clk);
    if (dl_if.dl_wait) begin
      n_checks++;
      $display("FAIL send_byte_timeout dl_wait still %0b, want 0", dl_if.dl_wait);
    end
    dl_if.dl_wr   = 1'b1;
    dl_if.dl_data = b;
    @(negedge clk);
    dl_if.dl_wr   = 1'b0;
  endtask

  task automatic start_dl();
    @(negedge clk);
    dl_if.dl_active = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic end_dl();
    dl_if.dl_active = 1'b0;
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    if (!done) begin
      n_checks++;
      $display("FAIL end_dl_timeout done=%0b, want 1", done);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (load_color !== 1'b0) $display("FAIL rst_load_color got %0b want 0", load_color); else n_pass++;
    n_checks++; if (load_color_index !== 6'd0) $display("FAIL rst_index got %0d want 0", load_color_index); else n_pass++;
    n_checks++; if (load_color_data !== 15'd0) $display("FAIL rst_data got %0h want 0", load_color_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %0b want 0", done); else n_pass++;
    n_checks++; if (entries_loaded !== 7'd0) $display("FAIL rst_entries got %0d want 0", entries_loaded); else n_pass++;
    n_checks++; if (dl_if.dl_wait !== 1'b0) $display("FAIL rst_dl_wait got %0b want 0", dl_if.dl_wait); else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_download();
    int base;
    int bad_idx;
    int bad_data;
    base = wr_total;
    start_dl();
    n_checks++; if (busy !== 1'b1) $display("FAIL full_busy_start got %0b want 1", busy); else n_pass++;
    send_byte(pat(0));
    send_byte(pat(1));
    send_byte(pat(2));
    n_checks++; if (dl_if.dl_wait !== 1'b1 || load_color !== 1'b0)
      $display("FAIL full_t1 wait=%0b lc=%0b want wait=1 lc=0", dl_if.dl_wait, load_color); else n_pass++;
    @(negedge clk);
    n_checks++; if (dl_if.dl_wait !== 1'b1 || load_color !== 1'b1)
      $display("FAIL full_t2 wait=%0b lc=%0b want wait=1 lc=1", dl_if.dl_wait, load_color); else n_pass++;
    n_checks++; if (load_color_index !== 6'd0 || load_color_data !== 15'h061F)
      $display("FAIL full_first idx=%0d data=%0h want idx=0 data=61f", load_color_index, load_color_data); else n_pass++;
    @(negedge clk);
    n_checks++; if (dl_if.dl_wait !== 1'b0 || load_color !== 1'b0 || entries_loaded !== 7'd1)
      $display("FAIL full_t3 wait=%0b lc=%0b ent=%0d want 0 0 1", dl_if.dl_wait, load_color, entries_loaded); else n_pass++;
    n_checks++; if (load_color_index !== 6'd0 || load_color_data !== 15'h061F)
      $display("FAIL full_hold idx=%0d data=%0h want idx=0 data=61f", load_color_index, load_color_data); else n_pass++;
    for (int k = 3; k < 192; k++) send_byte(pat(k));
    end_dl();
    n_checks++; if (wr_total - base !== 64) $display("FAIL full_writes got %0d want 64", wr_total - base); else n_pass++;
    n_checks++; if (entries_loaded !== 7'd64) $display("FAIL full_entries got %0d want 64", entries_loaded); else n_pass++;
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL full_end done=%0b busy=%0b want 1 0", done, busy); else n_pass++;
    bad_idx = 0;
    bad_data = 0;
    for (int e = 0; e < 64; e++) begin
      if (idx_log[base + e] !== 6'(e)) bad_idx++;
      if (data_log[base + e] !== pack(pat(3 * e), pat(3 * e + 1), pat(3 * e + 2))) bad_data++;
    end
    n_checks++; if (bad_idx !== 0) $display("FAIL full_idx_seq got %0d bad want 0", bad_idx); else n_pass++;
    n_checks++; if (bad_data !== 0) $display("FAIL full_data_seq got %0d bad want 0", bad_data); else n_pass++;
  endtask

  task automatic test_oversize();
    int base;
    base = wr_total;
    start_dl();
    n_checks++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL over_start done=%0b busy=%0b want 0 1", done, busy); else n_pass++;
    for (int k = 0; k < 198; k++) send_byte(pat(k));
    repeat (4) @(negedge clk);
    end_dl();
    n_checks++; if (wr_total - base !== 64) $display("FAIL over_writes got %0d want 64", wr_total - base); else n_pass++;
    n_checks++; if (entries_loaded !== 7'd64) $display("FAIL over_entries got %0d want 64", entries_loaded); else n_pass++;
    n_checks++; if (idx_log[base + 63] !== 6'd63) $display("FAIL over_last_idx got %0d want 63", idx_log[base + 63]); else n_pass++;
  endtask

  task automatic test_partial();
    int base;
    base = wr_total;
    start_dl();
    for (int k = 0; k < 7; k++) send_byte(pat(k));
    end_dl();
    n_checks++; if (wr_total - base !== 2) $display("FAIL part_writes got %0d want 2", wr_total - base); else n_pass++;
    n_checks++; if (idx_log[base] !== 6'd0 || idx_log[base + 1] !== 6'd1)
      $display("FAIL part_idx got %0d,%0d want 0,1", idx_log[base], idx_log[base + 1]); else n_pass++;
    n_checks++; if (data_log[base + 1] !== pack(pat(3), pat(4), pat(5)))
      $display("FAIL part_data1 got %0h want %0h", data_log[base + 1], pack(pat(3), pat(4), pat(5))); else n_pass++;
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || entries_loaded !== 7'd2)
      $display("FAIL part_end done=%0b busy=%0b ent=%0d want 1 0 2", done, busy, entries_loaded); else n_pass++;
  endtask

  task automatic test_violation();
    int base;
    base = wr_total;
    start_dl();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    dl_if.dl_wr   = 1'b1;
    dl_if.dl_data = 8'hAA;
    @(negedge clk);
    dl_if.dl_wr   = 1'b0;
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    repeat (4) @(negedge clk);
    end_dl();
    n_checks++; if (wr_total - base !== 2) $display("FAIL viol_writes got %0d want 2", wr_total - base); else n_pass++;
    n_checks++; if (data_log[base] !== pack(8'h11, 8'h22, 8'h33))
      $display("FAIL viol_data0 got %0h want %0h", data_log[base], pack(8'h11, 8'h22, 8'h33)); else n_pass++;
    n_checks++; if (idx_log[base + 1] !== 6'd1 || data_log[base + 1] !== pack(8'h44, 8'h55, 8'h66))
      $display("FAIL viol_entry1 idx=%0d data=%0h want 1 %0h", idx_log[base + 1], data_log[base + 1], pack(8'h44, 8'h55, 8'h66)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base;
    start_dl();
    for (int k = 0; k < 100; k++) send_byte(pat(k));
    #2;
    reset = 1'b1;
    dl_if.dl_active = 1'b0;
    #1;
    n_checks++; if (load_color !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dl_if.dl_wait !== 1'b0)
      $display("FAIL rmid_ctrl lc=%0b busy=%0b done=%0b wait=%0b want all 0", load_color, busy, done, dl_if.dl_wait); else n_pass++;
    n_checks++; if (load_color_index !== 6'd0 || load_color_data !== 15'd0 || entries_loaded !== 7'd0)
      $display("FAIL rmid_data idx=%0d data=%0h ent=%0d want all 0", load_color_index, load_color_data, entries_loaded); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    base = wr_total;
    repeat (20) @(negedge clk);
    n_checks++; if (wr_total - base !== 0) $display("FAIL rmid_no_write got %0d want 0", wr_total - base); else n_pass++;
    start_dl();
    send_byte(8'h18);
    send_byte(8'h28);
    send_byte(8'h38);
    repeat (4) @(negedge clk);
    end_dl();
    n_checks++; if (wr_total - base !== 1 || idx_log[base] !== 6'd0)
      $display("FAIL rmid_restart writes=%0d idx=%0d want 1 0", wr_total - base, idx_log[base]); else n_pass++;
    n_checks++; if (data_log[base] !== 15'h1CA3)
      $display("FAIL rmid_restart_data got %0h want 1ca3", data_log[base]); else n_pass++;
  endtask

`ifdef PAL_LOADER_VBLANK_GATE_EN
  task automatic test_gate();
    int bad_wait;
    int bad_lc;
    vblank = 1'b0;
    start_dl();
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    bad_wait = 0;
    bad_lc = 0;
    for (int i = 0; i < 500; i++) begin
      if (dl_if.dl_wait !== 1'b1) bad_wait++;
      if (load_color !== 1'b0) bad_lc++;
      @(negedge clk);
    end
    n_checks++; if (bad_wait !== 0) $display("FAIL gate_wait_held got %0d low cycles want 0", bad_wait); else n_pass++;
    n_checks++; if (bad_lc !== 0) $display("FAIL gate_no_write got %0d write cycles want 0", bad_lc); else n_pass++;
    vblank = 1'b1;
    @(negedge clk);
    n_checks++; if (load_color !== 1'b0) $display("FAIL gate_m got %0b want 0", load_color); else n_pass++;
    @(negedge clk);
    n_checks++; if (load_color !== 1'b1) $display("FAIL gate_m1 got %0b want 1", load_color); else n_pass++;
    repeat (2) @(negedge clk);
    end_dl();
  endtask
`endif

  initial begin
    reset           = 1'b1;
    dl_if.dl_active = 1'b0;
    dl_if.dl_wr     = 1'b0;
    dl_if.dl_data   = 8'h00;
`ifdef PAL_LOADER_VBLANK_GATE_EN
    vblank          = 1'b1;
`else
    vblank          = 1'b0;
`endif
    test_reset();
    test_full_download();
    test_oversize();
    test_partial();
    test_violation();
    test_reset_mid();
`ifdef PAL_LOADER_VBLANK_GATE_EN
    test_gate();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
